// File: rtl/calc_text_buffer_if.sv
// Evaluator link for the calculator entry buffer: request, frozen read port, result stream.
// master = buffer side (raises eval_req, serves eval_rd_char/expr_len), slave = evaluator side.
// Result stream has no backpressure; the buffer accepts one character per res_valid strobe.
interface calc_text_buffer_if #(
    parameter int MAX_LEN = 32
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             eval_req;
    logic [LEN_W-1:0] eval_rd_idx;
    logic [7:0]       eval_rd_char;
    logic [LEN_W-1:0] expr_len;
    logic             res_valid;
    logic [7:0]       res_char;
    logic             res_last;
    logic             res_err;

    modport master (
        output eval_req, eval_rd_char, expr_len,
        input  eval_rd_idx, res_valid, res_char, res_last, res_err
    );

    modport slave (
        input  eval_req, eval_rd_char, expr_len,
        output eval_rd_idx, res_valid, res_char, res_last, res_err
    );
endinterface

// File: rtl/calc_text_buffer.sv
// Calculator entry buffer: edits an expression from key events, hands it to an evaluator, shows the result.
// Latency: key/result strobes take effect on the next clk edge; rd_char and eval_rd_char are combinational.
// Backpressure: none; keys and result characters are taken every strobe, excess characters set overflow.
// Ports: clk/reset; key_ascii/key_pressed key events; rd_col/rd_char/cursor_col/cursor_on renderer;
//        hl_key/hl_active key highlight; eval_if evaluator link; overflow sticky drop flag.
module calc_text_buffer #(
    parameter int MAX_LEN      = 32,
    parameter int VIS_CHARS    = 10,
    parameter int HL_CYCLES    = 12,
    parameter int BLINK_CYCLES = 12500000,
    localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   key_ascii,
    input  logic                         key_pressed,
    input  logic [$clog2(VIS_CHARS)-1:0] rd_col,
    output logic [7:0]                   rd_char,
    output logic [$clog2(VIS_CHARS+1)-1:0] cursor_col,
    output logic                         cursor_on,
    output logic [7:0]                   hl_key,
    output logic                         hl_active,
    calc_text_buffer_if.master           eval_if,
    output logic                         overflow
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CUR_W = $clog2(VIS_CHARS + 1);
    localparam int HL_W  = $clog2(HL_CYCLES + 1);
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_VIS = LEN_W'(VIS_CHARS);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [7:0]       SPACE   = 8'h20;

    typedef enum logic [1:0] {EDIT, WAIT_EVAL, SHOW_RESULT} state_t;
    state_t state_q, state_d;

    logic [7:0]       buf_q [MAX_LEN];
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_dec;
    logic [IDX_W-1:0] wr_idx, del_idx;
    logic             res_started_q;   // first result char already replaced the expression
    logic             overflow_q;
    logic [HL_W-1:0]  hl_cnt_q;
    logic [7:0]       hl_key_q;
    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_phase_q;

    // Key decode
    logic is_digit, is_point, is_op, is_entry, is_enter, is_ac, is_del;
    always_comb begin
        is_digit = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
        is_point = (key_ascii == 8'h2E);
        is_op    = (key_ascii == 8'h2B) || (key_ascii == 8'h2D) ||
                   (key_ascii == 8'h2A) || (key_ascii == 8'h2F);
        is_entry = is_digit || is_point || is_op;
        is_enter = (key_ascii == 8'd10) || (key_ascii == 8'h3D);
        is_ac    = (key_ascii == 8'd27);
        is_del   = (key_ascii == 8'd8);
    end

    assign len_dec = len_q - 1'b1;
    assign wr_idx  = len_q[IDX_W-1:0];
    assign del_idx = len_dec[IDX_W-1:0];

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EDIT;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EDIT:
                if (key_pressed && is_enter && (len_q != '0)) state_d = WAIT_EVAL;
            WAIT_EVAL:
                // AC outranks any result strobe; an error outranks a normal character
                if (key_pressed && is_ac)                  state_d = EDIT;
                else if (eval_if.res_err)                  state_d = SHOW_RESULT;
                else if (eval_if.res_valid && eval_if.res_last) state_d = SHOW_RESULT;
            SHOW_RESULT:
                if (key_pressed && (is_entry || is_del || is_ac)) state_d = EDIT;
            default: state_d = EDIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        eval_if.eval_req = (state_q == WAIT_EVAL) && !res_started_q;
        cursor_on        = blink_phase_q && (state_q == EDIT) && (len_q < LEN_MAX);
    end

    // Buffer, length, overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
            len_q         <= '0;
            overflow_q    <= 1'b0;
            res_started_q <= 1'b0;
        end else begin
            case (state_q)
                EDIT: if (key_pressed) begin
                    if (is_ac) begin
                        for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
                        len_q      <= '0;
                        overflow_q <= 1'b0;
                    end else if (is_del) begin
                        if (len_q != '0) begin
                            buf_q[del_idx] <= SPACE;
                            len_q          <= len_dec;
                        end
                    end else if (is_entry) begin
                        if (len_q < LEN_MAX) begin
                            buf_q[wr_idx] <= key_ascii;
                            len_q         <= len_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                WAIT_EVAL: begin
                    if (key_pressed && is_ac) begin
                        for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
                        len_q         <= '0;
                        overflow_q    <= 1'b0;
                        res_started_q <= 1'b0;
                    end else if (eval_if.res_err) begin
                        for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
                        buf_q[0]      <= 8'h45;  // "E"
                        len_q         <= LEN_W'(1);
                        res_started_q <= 1'b0;
                    end else if (eval_if.res_valid) begin
                        if (!res_started_q) begin
                            for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
                            buf_q[0]      <= eval_if.res_char;
                            len_q         <= LEN_W'(1);
                            res_started_q <= !eval_if.res_last;
                        end else begin
                            if (len_q < LEN_MAX) begin
                                buf_q[wr_idx] <= eval_if.res_char;
                                len_q         <= len_q + 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                            if (eval_if.res_last) res_started_q <= 1'b0;
                        end
                    end
                end
                SHOW_RESULT: if (key_pressed) begin
                    if (is_digit || is_point) begin
                        // A number starts a fresh expression
                        for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
                        buf_q[0] <= key_ascii;
                        len_q    <= LEN_W'(1);
                    end else if (is_op) begin
                        // An operator chains onto the shown result
                        if (len_q < LEN_MAX) begin
                            buf_q[wr_idx] <= key_ascii;
                            len_q         <= len_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else if (is_del || is_ac) begin
                        for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= SPACE;
                        len_q <= '0;
                        if (is_ac) overflow_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key highlight and cursor blink timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hl_cnt_q      <= '0;
            hl_key_q      <= 8'h00;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            if (key_pressed) begin
                hl_cnt_q <= HL_W'(HL_CYCLES);
                hl_key_q <= key_ascii;
            end else if (hl_cnt_q != '0) begin
                hl_cnt_q <= hl_cnt_q - 1'b1;
            end
            // A key restarts the blink so the cursor is visible while typing
            if (key_pressed) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= 1'b1;
            end else if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= !blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // Scrolled view: the window keeps the tail of the expression visible
    logic [LEN_W-1:0] view_off;
    logic [LEN_W:0]   rd_pos;
    always_comb begin
        view_off   = (len_q > LEN_VIS) ? (len_q - LEN_VIS) : '0;
        rd_pos     = {1'b0, view_off} + (LEN_W+1)'(rd_col);
        rd_char    = (rd_pos < {1'b0, len_q}) ? buf_q[rd_pos[IDX_W-1:0]] : SPACE;
        cursor_col = (len_q > LEN_VIS) ? CUR_W'(VIS_CHARS) : CUR_W'(len_q);
        eval_if.eval_rd_char = (eval_if.eval_rd_idx < len_q) ?
                               buf_q[eval_if.eval_rd_idx[IDX_W-1:0]] : SPACE;
        eval_if.expr_len     = len_q;
    end

    assign hl_key    = hl_key_q;
    assign hl_active = (hl_cnt_q != '0);
    assign overflow  = overflow_q;
endmodule
